// File: rtl/seq_delay_checker_if.sv
// Bus bundle for seq_delay_checker: stimulus inputs (en/clr/a/b) and all
// checker results. The master side drives stimulus; the slave is the checker.
interface seq_delay_checker_if #(
    parameter int NUM_CH = 1,
    parameter int CNT_W  = 16
);
    logic              en;
    logic              clr;
    logic [NUM_CH-1:0] a;
    logic [NUM_CH-1:0] b;
    logic [NUM_CH-1:0] pass;
    logic [NUM_CH-1:0] fail;
    logic              busy;
    logic [CNT_W-1:0]  pass_cnt;
    logic [CNT_W-1:0]  fail_cnt;
    logic [4:0]        first_ch;
    logic [31:0]       first_time;
    logic              first_vld;

    modport master (
        output en, clr, a, b,
        input  pass, fail, busy, pass_cnt, fail_cnt, first_ch, first_time, first_vld
    );

    modport slave (
        input  en, clr, a, b,
        output pass, fail, busy, pass_cnt, fail_cnt, first_ch, first_time, first_vld
    );
endinterface

// File: rtl/seq_delay_checker.sv
// seq_delay_checker: per-channel checker for "a ##DELAY b".
// Each cycle with a=1 (and en=1) launches an attempt that resolves DELAY edges
// later as a one-cycle pass or fail pulse. Overlapping attempts are carried in
// a per-channel shift register, so no explicit per-attempt FSM is needed.
// Aggregate pass/fail counters saturate at all-ones.
// Optional feature (macro SEQ_CHK_FIRST_FAIL_EN): record channel and cycle
// stamp of the first fail since reset/clr. Without the macro those outputs
// are tied to zero.
module seq_delay_checker #(
    parameter int NUM_CH = 1,
    parameter int DELAY  = 2,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    seq_delay_checker_if.slave bus
);
    // Popcount must hold NUM_CH; the sum needs one extra bit beyond the wider
    // of counter and popcount so overflow is always visible before clamping.
    localparam int PC_W  = $clog2(NUM_CH + 1);
    localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;

    logic [NUM_CH-1:0][DELAY-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0]            pass_q, pass_d;
    logic [NUM_CH-1:0]            fail_q, fail_d;
    logic [CNT_W-1:0]             pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0]             fail_cnt_q, fail_cnt_d;

    function automatic logic [PC_W-1:0] popcount(input logic [NUM_CH-1:0] v);
        logic [PC_W-1:0] s;
        s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            s = s + PC_W'(v[i]);
        end
        return s;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                                 input logic [PC_W-1:0]  inc);
        logic [SUM_W-1:0] s;
        s = SUM_W'(cnt) + SUM_W'(inc);
        if (s > SUM_W'({CNT_W{1'b1}})) begin
            return {CNT_W{1'b1}};
        end
        return s[CNT_W-1:0];
    endfunction

    // Advance pending attempts and resolve those reaching the last stage.
    always_comb begin
        pend_d = '0;
        pass_d = '0;
        fail_d = '0;
        if (!bus.clr) begin
            for (int i = 0; i < NUM_CH; i++) begin
                for (int k = DELAY - 1; k >= 1; k--) begin
                    pend_d[i][k] = pend_q[i][k-1];
                end
                pend_d[i][0] = bus.a[i] & bus.en;
                pass_d[i]    = pend_q[i][DELAY-1] & bus.b[i];
                fail_d[i]    = pend_q[i][DELAY-1] & ~bus.b[i];
            end
        end
    end

    // Counters accumulate the registered pulses, one cycle behind them.
    always_comb begin
        pass_cnt_d = '0;
        fail_cnt_d = '0;
        if (!bus.clr) begin
            pass_cnt_d = sat_add(pass_cnt_q, popcount(pass_q));
            fail_cnt_d = sat_add(fail_cnt_q, popcount(fail_q));
        end
    end

    // Core state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q     <= '0;
            pass_q     <= '0;
            fail_q     <= '0;
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
        end else begin
            pend_q     <= pend_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            pass_cnt_q <= pass_cnt_d;
            fail_cnt_q <= fail_cnt_d;
        end
    end

    assign bus.pass     = pass_q;
    assign bus.fail     = fail_q;
    assign bus.busy     = |pend_q;
    assign bus.pass_cnt = pass_cnt_q;
    assign bus.fail_cnt = fail_cnt_q;

`ifdef SEQ_CHK_FIRST_FAIL_EN
    logic [31:0] cyc_q, cyc_d;
    logic        first_vld_q, first_vld_d;
    logic [4:0]  first_ch_q, first_ch_d;
    logic [31:0] first_time_q, first_time_d;

    // First-fail capture uses the fail being resolved this edge, so the flag
    // rises together with the fail pulse; the stamp keeps running through clr.
    always_comb begin
        cyc_d        = cyc_q + 32'd1;
        first_vld_d  = first_vld_q;
        first_ch_d   = first_ch_q;
        first_time_d = first_time_q;
        if (bus.clr) begin
            first_vld_d  = 1'b0;
            first_ch_d   = '0;
            first_time_d = '0;
        end else if (!first_vld_q && (|fail_d)) begin
            first_vld_d  = 1'b1;
            first_time_d = cyc_q;
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (fail_d[i]) begin
                    first_ch_d = 5'(i);
                end
            end
        end
    end

    // First-fail and cycle stamp registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q        <= '0;
            first_vld_q  <= 1'b0;
            first_ch_q   <= '0;
            first_time_q <= '0;
        end else begin
            cyc_q        <= cyc_d;
            first_vld_q  <= first_vld_d;
            first_ch_q   <= first_ch_d;
            first_time_q <= first_time_d;
        end
    end

    assign bus.first_vld  = first_vld_q;
    assign bus.first_ch   = first_ch_q;
    assign bus.first_time = first_time_q;
`else
    assign bus.first_vld  = 1'b0;
    assign bus.first_ch   = '0;
    assign bus.first_time = '0;
`endif

endmodule

// File: tb/tb_seq_delay_checker.sv
// Scoreboard bench for seq_delay_checker (NUM_CH=4, DELAY=2, CNT_W=6).
// The driver applies stimulus, updates an attempt-list reference model and
// queues the expected outputs; a negedge monitor pops and compares.
module tb_seq_delay_checker;
    localparam int NUM_CH = 4;
    localparam int DELAY  = 2;
    localparam int CNT_W  = 6;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic clk;
    logic rst;

    seq_delay_checker_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

    seq_delay_checker #(.NUM_CH(NUM_CH), .DELAY(DELAY), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          ch;
        longint      due;
    } att_t;

    typedef struct {
        longint      e;
        logic [3:0]  pass;
        logic [3:0]  fail;
        logic        busy;
        int          pcnt;
        int          fcnt;
        logic        vld;
        int          fch;
        logic [31:0] ftime;
    } exp_t;

    att_t   atts[$];
    exp_t   exp_q[$];

    longint      m_edge;
    logic [3:0]  m_pass, m_fail;
    int          m_pcnt, m_fcnt;
    logic        m_vld;
    int          m_fch;
    logic [31:0] m_ftime;
    logic [31:0] m_cyc;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input longint e, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s edge %0d actual %0h required %0h", nm, e, act, req);
        end
    endtask

    // Reference model of one clock edge.
    task automatic model(input bit r, input bit c, input bit e, input logic [3:0] av, input logic [3:0] bv);
        logic [3:0] np, nf;
        att_t keep[$];
        if (r || c) begin
            atts.delete();
            m_pass = '0; m_fail = '0;
            m_pcnt = 0;  m_fcnt = 0;
            m_vld = 1'b0; m_fch = 0; m_ftime = '0;
            m_cyc = r ? 32'd0 : m_cyc + 32'd1;
        end else begin
            m_pcnt = m_pcnt + $countones(m_pass);
            if (m_pcnt > CMAX) m_pcnt = CMAX;
            m_fcnt = m_fcnt + $countones(m_fail);
            if (m_fcnt > CMAX) m_fcnt = CMAX;
            np = '0; nf = '0;
            foreach (atts[i]) begin
                if (atts[i].due == m_edge) begin
                    if (bv[atts[i].ch]) np[atts[i].ch] = 1'b1;
                    else                nf[atts[i].ch] = 1'b1;
                end else begin
                    keep.push_back(atts[i]);
                end
            end
            atts = keep;
            if (e) begin
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    if (av[ch]) atts.push_back('{ch, m_edge + DELAY});
                end
            end
            if (!m_vld && nf != 0) begin
                m_vld = 1'b1;
                m_ftime = m_cyc;
                m_fch = 0;
                while (!nf[m_fch]) m_fch++;
            end
            m_cyc = m_cyc + 32'd1;
            m_pass = np; m_fail = nf;
        end
    endtask

    task automatic step(input bit r, input bit c, input bit e, input logic [3:0] av, input logic [3:0] bv);
        exp_t x;
        @(negedge clk);
        rst = r; bus.clr = c; bus.en = e; bus.a = av; bus.b = bv;
        model(r, c, e, av, bv);
        x.e = m_edge;
        x.pass = m_pass; x.fail = m_fail; x.busy = (atts.size() != 0);
        x.pcnt = m_pcnt; x.fcnt = m_fcnt;
`ifdef SEQ_CHK_FIRST_FAIL_EN
        x.vld = m_vld; x.fch = m_fch; x.ftime = m_ftime;
`else
        x.vld = 1'b0; x.fch = 0; x.ftime = '0;
`endif
        m_edge++;
        @(posedge clk);
        #1;
        exp_q.push_back(x);
    endtask

    // Monitor: every cycle the DUT presents a result set for the edge just past.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t x;
            x = exp_q.pop_front();
            chk("pass",       x.e, 64'(bus.pass),       64'(x.pass));
            chk("fail",       x.e, 64'(bus.fail),       64'(x.fail));
            chk("pass_fail_excl", x.e, 64'(bus.pass & bus.fail), 64'd0);
            chk("busy",       x.e, 64'(bus.busy),       64'(x.busy));
            chk("pass_cnt",   x.e, 64'(bus.pass_cnt),   64'(x.pcnt));
            chk("fail_cnt",   x.e, 64'(bus.fail_cnt),   64'(x.fcnt));
            chk("first_vld",  x.e, 64'(bus.first_vld),  64'(x.vld));
            chk("first_ch",   x.e, 64'(bus.first_ch),   64'(x.fch));
            chk("first_time", x.e, 64'(bus.first_time), 64'(x.ftime));
        end
    end

    initial begin
        rst = 1'b1; bus.clr = 1'b0; bus.en = 1'b0; bus.a = '0; bus.b = '0;
        m_edge = 0; m_cyc = '0;
        m_pass = '0; m_fail = '0; m_pcnt = 0; m_fcnt = 0;
        m_vld = 1'b0; m_fch = 0; m_ftime = '0;

        // Reset state.
        step(1, 0, 0, 4'h0, 4'h0);
        step(1, 0, 0, 4'h0, 4'h0);

        // Single attempt pass, then single attempt fail on channel 0.
        for (int i = 0; i < 8; i++) step(0, 0, 1, (i == 3) ? 4'h1 : 4'h0, (i == 5) ? 4'h1 : 4'h0);
        for (int i = 0; i < 8; i++) step(0, 0, 1, (i == 3) ? 4'h1 : 4'h0, 4'h0);

        // Held a with a gap in b: nine passes, one fail.
        step(0, 1, 1, 4'h0, 4'h0);
        for (int i = 0; i < 18; i++)
            step(0, 0, 1, (i >= 2 && i <= 11) ? 4'h1 : 4'h0,
                 ((i >= 4 && i <= 8) || (i >= 10 && i <= 13)) ? 4'h1 : 4'h0);

        // Reset mid-attempt, then clr mid-attempt.
        for (int i = 0; i < 8; i++) step(i == 4, 0, 1, (i == 3) ? 4'hF : 4'h0, 4'h0);
        for (int i = 0; i < 8; i++) step(0, i == 4, 1, (i == 3 || i == 4) ? 4'hF : 4'h0, 4'h0);

        // en drop: only the earlier attempt resolves.
        for (int i = 0; i < 9; i++) step(0, 0, i != 4, (i == 3 || i == 4) ? 4'h2 : 4'h0,
                                         (i == 5 || i == 6) ? 4'h2 : 4'h0);

        // Continuous all-fail: counter saturates, lowest fail channel recorded.
        step(0, 1, 1, 4'h0, 4'h0);
        for (int i = 0; i < 24; i++) step(0, 0, 1, 4'hF, 4'h0);
        for (int i = 0; i < 24; i++) step(0, 0, 1, 4'hC, 4'hC);

        // Randomized traffic with occasional clr/rst.
        for (int i = 0; i < 1500; i++) begin
            bit r, c, e;
            logic [3:0] av, bv;
            r  = ($urandom_range(0, 299) == 0);
            c  = ($urandom_range(0, 99) == 0);
            e  = ($urandom_range(0, 9) != 0);
            av = 4'($urandom_range(0, 15));
            bv = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15));
            step(r, c, e, av, bv);
        end

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        #2;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
